// File: rtl/unsigned28_unsigned8_divider_if.sv
// Operand/result handshake bundle for the 28/8 restoring divider.
// master = upstream producer and downstream consumer side, slave = the divider.
interface unsigned28_unsigned8_divider_if #(
  parameter int DW_A = 28,
  parameter int DW_B = 8,
  parameter int DW_Q = 20
);
  logic            in_valid;
  logic            in_ready;
  logic [DW_A-1:0] a;
  logic [DW_B-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [DW_Q-1:0] q;
  logic [DW_B-1:0] r;
  logic            div0;
  logic            ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div0, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div0, ovf
  );
endinterface

// File: rtl/unsigned28_unsigned8_divider.sv
// Sequential radix-2 restoring divider: 28-bit dividend / 8-bit divisor ->
// 20-bit quotient + 8-bit remainder, one bit per cycle, one operation in flight.
module unsigned28_unsigned8_divider #(
  parameter int DW_A = 28,
  parameter int DW_B = 8,
  parameter int DW_Q = 20
) (
  input logic clk,
  input logic rst_n,
  unsigned28_unsigned8_divider_if.slave bus
);

  localparam int CW = $clog2(DW_Q);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            in_ready_reg, out_valid_reg;
  logic [DW_Q-1:0] q_reg, q_next;
  logic [DW_B-1:0] r_reg, r_next;
  logic            div0_reg, div0_next;
  logic            ovf_reg, ovf_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [DW_Q-1:0] work, work_next;
  logic [DW_B-1:0] part, part_next;
  logic [DW_B-1:0] b_reg, b_next;

  logic [DW_B:0]   trial;
  logic            trial_ge;
  logic [DW_B-1:0] trial_diff;
  logic [DW_B-1:0] a_hi;

  // The difference is only kept when trial >= b, so it always fits DW_B bits.
  assign trial      = {part, work[DW_Q-1]};
  assign trial_ge   = trial >= {1'b0, b_reg};
  assign trial_diff = trial[DW_B-1:0] - b_reg;
  assign a_hi       = bus.a[DW_A-1:DW_Q];

  always_comb begin
    state_next = state;
    q_next     = q_reg;
    r_next     = r_reg;
    div0_next  = div0_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt;
    work_next  = work;
    part_next  = part;
    b_next     = b_reg;
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_reg) begin
          b_next = bus.b;
          if (bus.b == '0 || a_hi >= bus.b) begin
            div0_next  = (bus.b == '0);
            ovf_next   = 1'b1;
            q_next     = {DW_Q{1'b1}};
            r_next     = '0;
            state_next = DONE;
          end else begin
            part_next  = a_hi;
            work_next  = bus.a[DW_Q-1:0];
            cnt_next   = CW'(DW_Q - 1);
            state_next = CALC;
          end
        end
      end
      CALC: begin
        // work shifts dividend bits out at the top and quotient bits in at the bottom
        part_next = trial_ge ? trial_diff : trial[DW_B-1:0];
        work_next = {work[DW_Q-2:0], trial_ge};
        if (cnt == '0) begin
          q_next     = {work[DW_Q-2:0], trial_ge};
          r_next     = trial_ge ? trial_diff : trial[DW_B-1:0];
          div0_next  = 1'b0;
          ovf_next   = 1'b0;
          state_next = DONE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      r_reg         <= '0;
      div0_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      cnt           <= '0;
      work          <= '0;
      part          <= '0;
      b_reg         <= '0;
    end else begin
      state         <= state_next;
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_next == DONE);
      q_reg         <= q_next;
      r_reg         <= r_next;
      div0_reg      <= div0_next;
      ovf_reg       <= ovf_next;
      cnt           <= cnt_next;
      work          <= work_next;
      part          <= part_next;
      b_reg         <= b_next;
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.q         = q_reg;
  assign bus.r         = r_reg;
  assign bus.div0      = div0_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_unsigned28_unsigned8_divider.sv
// Directed and constrained-random checks for the 28/8 restoring divider,
// including error paths, back-pressure hold and mid-operation reset.
module tb_unsigned28_unsigned8_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  unsigned28_unsigned8_divider_if bus ();

  unsigned28_unsigned8_divider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers one operand pair, waits for acceptance, then counts edges until out_valid.
  task automatic applyStimulus(input logic [27:0] a_v, input logic [7:0] b_v, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (w >= 60) checkOutput("accept_timeout", 32'(w), 0);
    bus.a        = a_v;
    bus.b        = b_v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [27:0] a_v, input logic [7:0] b_v,
                        input logic [19:0] eq, input logic [7:0] er, input logic ediv,
                        input logic eovf, input int elat, input int hold);
    int lat;
    bus.out_ready = (hold == 0);
    applyStimulus(a_v, b_v, lat);
    checkOutput({tag, ".lat"},  32'(lat), 32'(elat));
    checkOutput({tag, ".q"},    32'(bus.q), 32'(eq));
    checkOutput({tag, ".r"},    32'(bus.r), 32'(er));
    checkOutput({tag, ".div0"}, 32'(bus.div0), 32'(ediv));
    checkOutput({tag, ".ovf"},  32'(bus.ovf), 32'(eovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) checkOutput({tag, ".held"}, 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, ".ov_drop"}, 32'(bus.out_valid), 0);
    checkOutput({tag, ".rdy_back"}, 32'(bus.in_ready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready), 1);
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 0);
    checkOutput({tag, ".q"},         32'(bus.q), 0);
    checkOutput({tag, ".r"},         32'(bus.r), 0);
    checkOutput({tag, ".div0"},      32'(bus.div0), 0);
    checkOutput({tag, ".ovf"},       32'(bus.ovf), 0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0]  rb;
    logic [7:0]  rhi;
    logic [19:0] rlo;
    logic [27:0] ra;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    #12;
    check_reset_values("rst_hold");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("rst_release");

    run_op("d1000_7",  28'd1000,      8'd7,   20'd142,     8'd6,   1'b0, 1'b0, 20, 0);
    run_op("max_ok",   28'hFEFFFFF,   8'd255, 20'hFFFFF,   8'd254, 1'b0, 1'b0, 20, 0);
    run_op("ovf_edge", 28'hFF00000,   8'd255, 20'hFFFFF,   8'd0,   1'b0, 1'b1, 0,  0);
    run_op("div_zero", 28'd123,       8'd0,   20'hFFFFF,   8'd0,   1'b1, 1'b1, 0,  0);
    run_op("ovf_eq",   28'h0700000,   8'd7,   20'hFFFFF,   8'd0,   1'b0, 1'b1, 0,  2);
    run_op("zero_num", 28'd0,         8'd1,   20'd0,       8'd0,   1'b0, 1'b0, 20, 0);
    run_op("by_one",   28'h00FFFFF,   8'd1,   20'hFFFFF,   8'd0,   1'b0, 1'b0, 20, 0);
    run_op("d_200",    28'h0123456,   8'd200, 20'd5965,    8'd46,  1'b0, 1'b0, 20, 1);

    // Back-pressure: stray in_valid during CALC and DONE must not start a new op.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.a = 28'd500;
    bus.b = 8'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 28'd9;
    bus.b = 8'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    lat = 5;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp.lat", 32'(lat), 20);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      checkOutput("bp.valid", 32'(bus.out_valid), 1);
      checkOutput("bp.q",     32'(bus.q), 166);
      checkOutput("bp.r",     32'(bus.r), 2);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp.ov_drop", 32'(bus.out_valid), 0);
    checkOutput("bp.q_kept",  32'(bus.q), 166);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("bp.no_second", 32'(seen), 0);

    // Abort mid-CALC with an asynchronous reset.
    @(negedge clk);
    bus.a = 28'd99999;
    bus.b = 8'd13;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("abort.no_result", 32'(seen), 0);
    run_op("after_abort", 28'd99999, 8'd13, 20'd7692, 8'd3, 1'b0, 1'b0, 20, 0);

    // Random non-overflowing operands against a reference divide.
    for (int n = 0; n < 200; n++) begin
      rb  = 8'($urandom_range(1, 255));
      rhi = 8'($urandom_range(0, int'(rb) - 1));
      rlo = 20'($urandom);
      ra  = {rhi, rlo};
      run_op("rand", ra, rb, 20'(ra / 28'(rb)), 8'(ra % 28'(rb)), 1'b0, 1'b0, 20,
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
